// File: rtl/scan_chain_ctrl_pkg.sv
// scan_chain_ctrl_pkg: shared state encoding and limits for the scan-chain controller
package scan_chain_ctrl_pkg;
  localparam int MAX_CHAIN_LEN = 256;
  typedef enum logic [1:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT} state_t;
endpackage

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: shifts a pattern into a scan chain, issues one capture, unloads the response
// Ports: CLK/RST (sync, active-high reset); START+PAT request a sequence; SO is the last chain flop;
//   SE/SI drive the chain; BUSY/DONE report progress; RESP is the parallel captured response.
// Optional SCAN_CHAIN_CTRL_COMPARE_EN adds EXP (expected response, sampled at START) and MISMATCH.
module scan_chain_ctrl
  import scan_chain_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
  input  logic [CHAIN_LEN-1:0] EXP,
  output logic                 MISMATCH,
`endif
  output logic [CHAIN_LEN-1:0] RESP
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] sr_q, sr_d, sr_sh, resp_q, resp_d;
  logic se_q, se_d, si_q, si_d, busy_q, busy_d, done_q, done_d;
  logic last, start_ok, shifting;
  assign last = cnt_q == CNT_W'(CHAIN_LEN - 1);
  // One register serves both directions: pattern leaves from the top, SO enters at the bottom.
  assign sr_sh = sr_q << 1;
  assign start_ok = state_q == IDLE && START;
  assign shifting = state_q == SHIFT_IN || state_q == SHIFT_OUT;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sr_q <= '0;
      resp_q <= '0;
      se_q <= 1'b0;
      si_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      resp_q <= resp_d;
      se_q <= se_d;
      si_q <= si_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = START ? SHIFT_IN : IDLE;
      SHIFT_IN:  state_d = last ? CAPTURE : SHIFT_IN;
      CAPTURE:   state_d = SHIFT_OUT;
      SHIFT_OUT: state_d = last ? IDLE : SHIFT_OUT;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d = shifting && !last ? cnt_q + 1'b1 : '0;
    sr_d = start_ok ? PAT : state_q == SHIFT_IN ? sr_sh : state_q == SHIFT_OUT ? sr_sh | CHAIN_LEN'(SO) : sr_q;
    se_d = state_d == SHIFT_IN || state_d == SHIFT_OUT;
    si_d = start_ok ? PAT[CHAIN_LEN-1] : state_q == SHIFT_IN && !last ? sr_sh[CHAIN_LEN-1] : 1'b0;
    busy_d = state_d != IDLE;
    done_d = state_q == SHIFT_OUT && last;
    resp_d = done_d ? sr_sh | CHAIN_LEN'(SO) : resp_q;
  end
  assign SE = se_q;
  assign SI = si_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign RESP = resp_q;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_q;
  logic mism_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      exp_q <= '0;
      mism_q <= 1'b0;
    end else begin
      exp_q <= start_ok ? EXP : exp_q;
      mism_q <= done_d ? |(resp_d ^ exp_q) : mism_q;
    end
  end
  assign MISMATCH = mism_q;
`endif
endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Scan-chain driver and unloader for the scan-flop library. It shifts a parallel test pattern serially into a chain of scan flip-flops through their SE/SI pins, and issues one functional capture clock. It then shifts the captured response out of the chain's last flop and presents it as a parallel word. It sits between on-chip test logic and any chain of scan D flip-flops clocked by the same CLK.

## Interface
- CHAIN_LEN, 16, number of scan flops in the chain (1..256)
- CNT_W, $clog2(CHAIN_LEN+1), bit-counter width (derived, not overridden)
- CLK  input  1  clock, shared with the scan chain
- RST  input  1  reset: synchronous, active-high; one clock.
- START  input  1  request one load/capture/unload sequence; sampled only in IDLE
- PAT  input  CHAIN_LEN  pattern; PAT[k] is destined for chain flop k (flop 0 is nearest SI)
- SO  input  1  Q of chain flop CHAIN_LEN-1
- SE  output  1  scan enable to every chain flop, registered
- SI  output  1  scan data into chain flop 0, registered
- BUSY  output  1  sequence in progress
- DONE  output  1  one-cycle pulse; RESP valid from this cycle
- RESP  output  CHAIN_LEN  captured response; RESP[k] = value captured by flop k

## Operation
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT (return to IDLE).
- IDLE, START=1 at edge t0:
  - copy PAT into an internal shift register;
  - set SE=1 and SI=PAT[CHAIN_LEN-1];
  - set BUSY=1 and go to SHIFT_IN.
- SHIFT_IN:
  - SI presents PAT bits MSB first: PAT[CHAIN_LEN-1] down to PAT[0].
  - The chain shifts on edges t1..tN, where N=CHAIN_LEN.
  - At tN: SE=0, SI=0, go to CAPTURE.
- CAPTURE: the chain captures functional D at tN+1. At tN+1: SE=1, go to SHIFT_OUT.
- SHIFT_OUT:
  - SO is sampled on edges tN+2..t2N+1 and shifted into RESP MSB first. The first sample is flop N-1; the last is flop 0.
  - SI=0 throughout.
  - At t2N+1: SE=0, BUSY=0, DONE=1, go to IDLE.
- START while BUSY: ignored, never queued. PAT changes after t0 are ignored.
- RESP holds its value until the next sequence's final sample. It is not cleared at START.
- The bit counter is CNT_W wide, counts 0..N-1 in each shift state, and never wraps past N-1.
- CHAIN_LEN=1 is legal: one shift edge, one capture edge, one unload edge.
- RST=1 at any edge has priority over every other event and applies the reset values below.
  - Mid-sequence RST aborts with no DONE.
  - A START on the first edge after RST deasserts is accepted.

## Timing
- Reset values: SE=0, SI=0, BUSY=0, DONE=0, RESP=0, state IDLE, counter 0.
- SE is high for exactly N cycles, low for 1 cycle, then high for N cycles.
- DONE is high for the single cycle after edge t0+2N+1. BUSY is high from t0 through t0+2N+1.
- Back-to-back operation: the earliest next START is sampled while DONE is high, at edge t0+2N+2.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- SCAN_CHAIN_CTRL_COMPARE_EN defined:
  - adds input EXP [CHAIN_LEN] and output MISMATCH [1];
  - EXP is sampled at START;
  - MISMATCH = |(RESP ^ EXP), registered, updated in the same cycle DONE rises, held until the next DONE, reset to 0.
- Macro undefined: neither port exists and the behaviour is otherwise identical.

## Structure
- Package scan_chain_ctrl_pkg holds:
  - the state enum typedef (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT);
  - a localparam for maximum CHAIN_LEN (256).
- Single module; no sub-module. The counter and shift registers are inline.
- The bench supplies a behavioural N-flop scan chain model with its own functional D input.

## Test plan
- RST high for 2 cycles mid-idle -> SE=0, SI=0, BUSY=0, DONE=0, RESP=0.
- CHAIN_LEN=4, PAT=4'b1011, model D=4'b0110 -> SI=1,0,1,1 on t1..t4; chain=1011 after t4; SE low only for t5; RESP=4'b0110 and DONE=1 in the cycle after t9.
- Model D=Q (hold), PAT=4'hA -> RESP=4'hA, exactly one DONE pulse.
- START pulsed again at t0+3 and t0+6 -> ignored; single DONE at t0+9; next START at t0+10 accepted.
- RST at t0+3 -> SE=0 and BUSY=0 after that edge, no DONE, RESP unchanged at 0; a new sequence completes normally.
- With SCAN_CHAIN_CTRL_COMPARE_EN: EXP=4'h6, D=4'h6 -> MISMATCH=0; EXP=4'h7 -> MISMATCH=1 coincident with DONE.
